// File: rtl/dff_share_arbiter.sv
// Shared WIDTH-bit register with round-robin grant and bounded lock.
// Ports: clk, rst_n, req/lock/wdata in; gnt, out, upd, owner out.
module dff_share_arbiter #(
  parameter int WIDTH    = 8,
  parameter int N_REQ    = 4,
  parameter int MAX_LOCK = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           lock,
  input  logic [N_REQ*WIDTH-1:0]     wdata,
  output logic [N_REQ-1:0]           gnt,
  output logic [WIDTH-1:0]           out,
  output logic                       upd,
  output logic [$clog2(N_REQ)-1:0]   owner
);

  localparam int IW  = $clog2(N_REQ);
  localparam int LCW = $clog2(MAX_LOCK + 1);
  localparam logic [LCW-1:0] CNT_MAX = LCW'(MAX_LOCK);
  localparam logic [IW-1:0]  LAST    = IW'(N_REQ - 1);

  typedef enum logic {
    ARB,
    LOCKED
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [LCW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             upd_q, upd_d;

  logic             rr_hit;
  logic [IW-1:0]    rr_idx;
  logic [IW-1:0]    scan_w;
  int               scan;
  logic             hold;
  logic             any;
  logic [IW-1:0]    gi;

  // Round-robin scan starting at ptr, wrapping modulo N_REQ
  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    scan   = 0;
    scan_w = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan   = (int'(ptr_q) + k) % N_REQ;
      scan_w = IW'(scan);
      if (!rr_hit && req[scan_w]) begin
        rr_hit = 1'b1;
        rr_idx = scan_w;
      end
    end
  end

  // Owner keeps the register while its window is still open
  assign hold = (state_q == LOCKED) &&
                req[owner_q] &&
                (cnt_q < CNT_MAX);

  assign any = hold || rr_hit;
  assign gi  = hold ? owner_q : rr_idx;

  always_comb begin
    gnt = '0;
    if (any && rst_n) begin
      gnt = N_REQ'(1) << gi;
    end
  end

  always_comb begin
    state_d = ARB;
    ptr_d   = ptr_q;
    cnt_d   = '0;
    owner_d = owner_q;
    out_d   = out_q;
    upd_d   = 1'b0;
    if (any) begin
      out_d   = wdata[int'(gi)*WIDTH +: WIDTH];
      owner_d = gi;
      upd_d   = 1'b1;
      ptr_d   = (gi == LAST) ? '0 : gi + IW'(1);
      unique case (1'b1)
        hold: begin
          if (lock[gi]) begin
            state_d = LOCKED;
            cnt_d   = cnt_q + LCW'(1);
          end
        end
        default: begin
          if (lock[gi] && (MAX_LOCK > 1)) begin
            state_d = LOCKED;
            cnt_d   = LCW'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      ptr_q   <= '0;
      cnt_q   <= '0;
      owner_q <= '0;
      out_q   <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      out_q   <= out_d;
      upd_q   <= upd_d;
    end
  end

  assign out   = out_q;
  assign upd   = upd_q;
  assign owner = owner_q;

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Directed bench for dff_share_arbiter.
// Drives req/lock/wdata, checks gnt, out, upd and owner.
module tb_dff_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [3:0]  lock;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [7:0]  out;
  logic        upd;
  logic [1:0]  owner;

  int n_chk;
  int n_fail;

  dff_share_arbiter #(
    .WIDTH(8),
    .N_REQ(4),
    .MAX_LOCK(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .lock(lock),
    .wdata(wdata),
    .gnt(gnt),
    .out(out),
    .upd(upd),
    .owner(owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setw(input int i, input logic [7:0] v);
    wdata[i*8 +: 8] = v;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    req    = '0;
    lock   = '0;
    wdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_out", out, 0);
    chk("rst_upd", upd, 0);
    chk("rst_owner", owner, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) setw(i, 8'h10 + 8'(i));
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_gnt", gnt, 32'(1) << (k % 4));
      tick();
      chk("rr_out", out, 32'h10 + 32'(k % 4));
      chk("rr_upd", upd, 1);
      chk("rr_owner", owner, 32'(k % 4));
    end

    req = 4'b0100;
    #1 chk("pre_wrap_gnt", gnt, 4'b0100);
    tick();
    req = 4'b0101;
    #1 chk("wrap_gnt", gnt, 4'b0001);
    tick();
    chk("wrap_out", out, 8'h10);
    #1 chk("skip_gnt", gnt, 4'b0100);
    tick();
    chk("skip_out", out, 8'h12);
    chk("skip_owner", owner, 2);
    req = 4'b1000;
    #1 chk("p3_gnt", gnt, 4'b1000);
    tick();

    req  = 4'b0011;
    lock = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      #1 chk("lock_hold_gnt", gnt, 4'b0001);
      tick();
    end
    #1 chk("forced_rel_gnt", gnt, 4'b0010);
    tick();
    chk("forced_rel_owner", owner, 1);
    chk("forced_rel_out", out, 8'h11);
    #1 chk("relock_gnt", gnt, 4'b0001);
    tick();
    req  = 4'b0000;
    lock = 4'b0000;
    #1 chk("drop_gnt", gnt, 0);
    tick();
    chk("drop_upd", upd, 0);

    req  = 4'b0100;
    lock = 4'b0100;
    #1 chk("lk2_a_gnt", gnt, 4'b0100);
    tick();
    #1 chk("lk2_b_gnt", gnt, 4'b0100);
    tick();
    req  = 4'b1001;
    lock = 4'b0000;
    #1 chk("early_rel_gnt", gnt, 4'b1000);
    tick();
    chk("early_rel_owner", owner, 3);
    #1 chk("after_rel_gnt", gnt, 4'b0001);
    tick();

    wdata = 'x;
    setw(2, 8'hA5);
    req = 4'b0100;
    #1 chk("a5_gnt", gnt, 4'b0100);
    tick();
    chk("a5_out", out, 8'hA5);
    chk("a5_owner", owner, 2);
    req = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      #1 chk("idle_gnt", gnt, 0);
      tick();
      chk("idle_upd", upd, 0);
      chk("idle_out", out, 8'hA5);
      chk("idle_owner", owner, 2);
    end

    for (int i = 0; i < 4; i++) setw(i, 8'h10 + 8'(i));
    req  = 4'b0010;
    lock = 4'b0010;
    tick();
    chk("pre_rst_owner", owner, 1);
    req = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", gnt, 0);
    chk("mid_rst_out", out, 0);
    chk("mid_rst_upd", upd, 0);
    chk("mid_rst_owner", owner, 0);
    tick();
    rst_n = 1'b1;
    lock  = 4'b0000;
    #1 chk("post_rst_gnt", gnt, 4'b0001);
    tick();
    chk("post_rst_out", out, 8'h10);
    chk("post_rst_upd", upd, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
